// File: rtl/stack_seq.sv
// Stack-access sequencer: owns the 6502 stack pointer and runs 1-3 byte push/pull bursts to page 1.
// Optional sticky wrap flag is built when STACK_WRAP_FLAG_EN is defined.
module stack_seq #(
    parameter int          DATA_W     = 8,
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter logic [7:0]  SP_RESET   = 8'hFD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  dir,
    input  logic [1:0]            count,
    input  logic [3*DATA_W-1:0]   push_data,
    output logic [3*DATA_W-1:0]   pull_data,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            sp,
    input  logic                  sp_load,
    input  logic [7:0]            sp_load_val,
    output logic [15:0]           mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  sp_wrap
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            sp_q, sp_d;
    logic [1:0]            idx_q, idx_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  dir_q, dir_d;
    logic [3*DATA_W-1:0]   push_q, push_d;
    logic [3*DATA_W-1:0]   pull_q, pull_d;
    logic                  wrap_set;
    logic                  load_ok;
    logic                  xfer;
    logic [7:0]            sp_inc;
    logic [1:0]            push_sel;

    assign xfer     = (state_q == S_XFER);
    assign sp_inc   = sp_q + 8'd1;
    // Push sends the highest requested byte first, so index counts down from cnt-1.
    assign push_sel = cnt_q - 2'd1 - idx_q;
    assign load_ok  = sp_load && !xfer;

    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        push_d   = push_q;
        pull_d   = pull_q;
        wrap_set = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (sp_load) begin
                    sp_d = sp_load_val;
                end
                if (start && (count != 2'd0)) begin
                    state_d = S_XFER;
                    dir_d   = dir;
                    cnt_d   = count;
                    idx_d   = 2'd0;
                    if (dir) begin
                        push_d = push_data;
                    end else begin
                        pull_d = '0;
                    end
                end
            end
            S_XFER: begin
                if (mem_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (dir_q) begin
                        sp_d     = sp_q - 8'd1;
                        wrap_set = (sp_q == 8'h00);
                    end else begin
                        sp_d     = sp_inc;
                        wrap_set = (sp_q == 8'hFF);
                        pull_d[idx_q*DATA_W +: DATA_W] = mem_rdata;
                    end
                    if (idx_q == cnt_q - 2'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sp_q    <= SP_RESET;
            idx_q   <= 2'd0;
            cnt_q   <= 2'd0;
            dir_q   <= 1'b0;
            pull_q  <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pull_q  <= pull_d;
        end
    end

    // Push bytes are only consumed while dir_q says push, so they need no reset.
    always_ff @(posedge clk) begin
        push_q <= push_d;
    end

`ifdef STACK_WRAP_FLAG_EN
    logic wrap_q, wrap_d;

    always_comb begin
        wrap_d = wrap_q;
        if (wrap_set) begin
            wrap_d = 1'b1;
        end else if (load_ok) begin
            wrap_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign sp_wrap = wrap_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap_set ^ load_ok;
    assign sp_wrap     = 1'b0;
`endif

    always_comb begin
        mem_we    = xfer && dir_q;
        mem_re    = xfer && !dir_q;
        mem_addr  = 16'h0000;
        mem_wdata = '0;
        if (xfer) begin
            mem_addr = {STACK_PAGE, (dir_q ? sp_q : sp_inc)};
        end
        if (xfer && dir_q) begin
            mem_wdata = push_q[push_sel*DATA_W +: DATA_W];
        end
    end

    assign busy      = xfer;
    assign done      = (state_q == S_DONE);
    assign sp        = sp_q;
    assign pull_data = pull_q;

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq: table of push/pull operations plus hand-written corner sequences.
module tb_stack_seq;

`ifdef STACK_WRAP_FLAG_EN
    localparam logic W = 1'b1;
`else
    localparam logic W = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [1:0]  count = 2'd0;
    logic [23:0] push_data = 24'h0;
    logic [23:0] pull_data;
    logic        busy, done;
    logic [7:0]  sp;
    logic        sp_load = 1'b0;
    logic [7:0]  sp_load_val = 8'h00;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we, mem_re;
    logic [7:0]  mem_rdata;
    logic        mem_ready = 1'b1;
    logic        sp_wrap;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:255];
    logic [15:0] log_addr [0:3];
    logic [7:0]  log_data [0:3];

    stack_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .count(count),
        .push_data(push_data), .pull_data(pull_data), .busy(busy), .done(done),
        .sp(sp), .sp_load(sp_load), .sp_load_val(sp_load_val),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .sp_wrap(sp_wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we && mem_ready) mem[mem_addr[7:0]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[7:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ld;
        logic [7:0]  ldv;
        logic        d;
        logic [1:0]  n;
        logic [23:0] pd;
        logic [7:0]  sp;
        logic [23:0] pull;
        logic        wrap;
        int          cyc;
        logic [15:0] a0;
        logic [7:0]  d0;
        logic [15:0] al;
        logic [7:0]  dl;
    } vec_t;

    vec_t vecs [0:7];

    // Called right after a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input vec_t v, output int ncyc, output int nacc);
        start = 1'b1; dir = v.d; count = v.n; push_data = v.pd;
        sp_load = v.ld; sp_load_val = v.ldv;
        @(negedge clk);
        start = 1'b0; sp_load = 1'b0;
        ncyc = 0; nacc = 0;
        for (int c = 1; c <= 20; c++) begin
            if ((mem_we || mem_re) && nacc < 4) begin
                log_addr[nacc] = mem_addr;
                log_data[nacc] = mem_we ? mem_wdata : mem_rdata;
                nacc++;
            end
            if (done) begin
                ncyc = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ncyc, nacc;

        vecs[0] = '{1'b0, 8'h00, 1'b1, 2'd3, 24'hC0DE42, 8'hFA, 24'h000000, 1'b0, 4, 16'h01FD, 8'hC0, 16'h01FB, 8'h42};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 2'd3, 24'h000000, 8'hFD, 24'hC0DE42, 1'b0, 4, 16'h01FB, 8'h42, 16'h01FD, 8'hC0};
        vecs[2] = '{1'b1, 8'h00, 1'b1, 2'd1, 24'h0000AA, 8'hFF, 24'hC0DE42, W,    2, 16'h0100, 8'hAA, 16'h0100, 8'hAA};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 2'd1, 24'h000000, 8'h00, 24'h0000AA, W,    2, 16'h0100, 8'hAA, 16'h0100, 8'hAA};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 2'd2, 24'h001234, 8'hFE, 24'h0000AA, W,    3, 16'h0100, 8'h12, 16'h01FF, 8'h34};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 2'd2, 24'h000000, 8'h00, 24'h001234, W,    3, 16'h01FF, 8'h34, 16'h0100, 8'h12};
        vecs[6] = '{1'b1, 8'h80, 1'b1, 2'd1, 24'h000055, 8'h7F, 24'h001234, 1'b0, 2, 16'h0180, 8'h55, 16'h0180, 8'h55};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 2'd1, 24'h000000, 8'h80, 24'h000055, 1'b0, 2, 16'h0180, 8'h55, 16'h0180, 8'h55};

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_sp", sp, 8'hFD);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_re", mem_re, 0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_wdata", mem_wdata, 8'h00);
        chk("rst_pull", pull_data, 24'h0);
        chk("rst_wrap", sp_wrap, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of operations with mem_ready high
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], ncyc, nacc);
            chk($sformatf("v%0d_cyc", i), ncyc, vecs[i].cyc);
            chk($sformatf("v%0d_nacc", i), nacc, {30'd0, vecs[i].n});
            chk($sformatf("v%0d_busy", i), busy, 0);
            chk($sformatf("v%0d_sp", i), sp, vecs[i].sp);
            chk($sformatf("v%0d_pull", i), pull_data, vecs[i].pull);
            chk($sformatf("v%0d_wrap", i), sp_wrap, vecs[i].wrap);
            chk($sformatf("v%0d_a0", i), log_addr[0], vecs[i].a0);
            chk($sformatf("v%0d_d0", i), log_data[0], vecs[i].d0);
            chk($sformatf("v%0d_al", i), log_addr[nacc > 0 ? nacc - 1 : 0], vecs[i].al);
            chk($sformatf("v%0d_dl", i), log_data[nacc > 0 ? nacc - 1 : 0], vecs[i].dl);
        end
        chk("mid_byte_01FC", mem[8'hFC], 8'hDE);
        @(negedge clk);
        chk("idle_done", done, 0);

        // Pull 2 from loaded SP=FA with two wait cycles on byte 0; busy-time start/load ignored
        start = 1'b1; dir = 1'b0; count = 2'd2; sp_load = 1'b1; sp_load_val = 8'hFA; mem_ready = 1'b0;
        @(negedge clk); // cycle 1
        start = 1'b0; sp_load = 1'b0;
        chk("w1_addr", mem_addr, 16'h01FB);
        chk("w1_re", mem_re, 1);
        chk("w1_sp", sp, 8'hFA);
        start = 1'b1; dir = 1'b1; count = 2'd3; sp_load = 1'b1; sp_load_val = 8'h33;
        @(negedge clk); // cycle 2
        start = 1'b0; sp_load = 1'b0;
        chk("w2_addr", mem_addr, 16'h01FB);
        chk("w2_re", mem_re, 1);
        chk("w2_we", mem_we, 0);
        chk("w2_sp", sp, 8'hFA);
        @(negedge clk); // cycle 3
        chk("w3_addr", mem_addr, 16'h01FB);
        chk("w3_sp", sp, 8'hFA);
        mem_ready = 1'b1;
        @(negedge clk); // cycle 4
        chk("w4_addr", mem_addr, 16'h01FC);
        chk("w4_sp", sp, 8'hFB);
        chk("w4_done", done, 0);
        @(negedge clk); // cycle 5
        chk("w5_done", done, 1);
        chk("w5_busy", busy, 0);
        chk("w5_sp", sp, 8'hFC);
        chk("w5_pull", pull_data, 24'h00DE42);
        @(negedge clk);
        chk("w6_busy", busy, 0);
        chk("w6_done", done, 0);

        // start with count=0 is ignored
        start = 1'b1; dir = 1'b1; count = 2'd0;
        @(negedge clk);
        start = 1'b0;
        chk("z_busy", busy, 0);
        chk("z_we", mem_we, 0);
        chk("z_sp", sp, 8'hFC);
        @(negedge clk);
        chk("z_done", done, 0);

        // Back-to-back push 1 / push 1 with start during done
        start = 1'b1; dir = 1'b1; count = 2'd1; push_data = 24'h000011;
        @(negedge clk);
        start = 1'b0;
        chk("b1_addr", mem_addr, 16'h01FC);
        chk("b1_wdata", mem_wdata, 8'h11);
        @(negedge clk);
        chk("b2_done", done, 1);
        start = 1'b1; push_data = 24'h000022;
        @(negedge clk);
        start = 1'b0;
        chk("b3_busy", busy, 1);
        chk("b3_addr", mem_addr, 16'h01FB);
        chk("b3_wdata", mem_wdata, 8'h22);
        @(negedge clk);
        chk("b4_done", done, 1);
        chk("b4_sp", sp, 8'hFA);

        // Reset in cycle 2 of a push 3
        start = 1'b1; dir = 1'b1; count = 2'd3; push_data = 24'h123456;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("r2_we", mem_we, 1);
        chk("r2_addr", mem_addr, 16'h01F9);
        chk("r2_wdata", mem_wdata, 8'h34);
        #2 rst_n = 1'b0;
        #1;
        chk("r_we_drop", mem_we, 0);
        chk("r_busy", busy, 0);
        chk("r_addr", mem_addr, 16'h0000);
        chk("r_wdata", mem_wdata, 8'h00);
        chk("r_sp", sp, 8'hFD);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("r_done_after", done, 0);
        chk("r_busy_after", busy, 0);
        chk("r_sp_after", sp, 8'hFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_seq.md
# stack_seq

Stack-access sequencer for the 6502 core. Owns the 8-bit stack pointer and runs 1–3 byte push or pull sequences to page 1 (`{STACK_PAGE, SP}`) over a ready-handshaked memory port. Push post-decrements SP and pull pre-increments it, the counterpart of the shared increment/decrement path. It sits between the control sequencer, which issues PHA/PLA/JSR/RTS/BRK/RTI/IRQ stack operations, and the bus arbiter.

## Interface
- `DATA_W`, 8, byte width
- `STACK_PAGE`, 8'h01, high address byte of stack
- `SP_RESET`, 8'hFD, SP value after reset
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled when `busy`=0
- `dir`  in  1  1 = push, 0 = pull; sampled with `start`
- `count`  in  2  number of bytes, 1–3; 0 means no operation
- `push_data`  in  24  bytes to push; sampled with `start`
- `pull_data`  out  24  pulled bytes
- `busy`  out  1  a sequence is in progress
- `done`  out  1  one-cycle completion pulse
- `sp`  out  8  current stack pointer
- `sp_load`  in  1  load SP from `sp_load_val` (TXS)
- `sp_load_val`  in  8  value loaded into SP
- `mem_addr`  out  16  stack address
- `mem_wdata`  out  8  write byte
- `mem_we`  out  1  write strobe
- `mem_re`  out  1  read strobe
- `mem_rdata`  in  8  read byte
- `mem_ready`  in  1  bus accepts/completes the current access
- `sp_wrap`  out  1  sticky wrap flag (see Configuration)

## Operation
- FSM states: IDLE, XFER, DONE. Reset → IDLE.
- IDLE/DONE with `start`=1 and `count`≠0 → XFER. Latch `dir` and `count`, latch `push_data` (push only), clear the byte index `idx` to 0. `start` with `count`=0 is ignored.
- `start` is ignored while `busy`=1.
- Push byte order is high byte first. For `count` N, byte k (k = 0..N−1) is `push_data[8(N−1−k) +: 8]`.
  - `mem_addr` = `{STACK_PAGE, sp}`, `mem_we`=1.
  - On the edge where `mem_ready`=1: `sp` ← `sp`−1 and `idx` increments.
- Pull byte order is low byte first. Byte k goes to `pull_data[8k +: 8]`.
  - `mem_addr` = `{STACK_PAGE, sp+1}`, `mem_re`=1.
  - On the edge where `mem_ready`=1: `sp` ← `sp`+1 and `mem_rdata` is captured.
  - Unused upper `pull_data` bytes are cleared to 0 at pull start.
- This ordering makes a push of N followed by a pull of N return identical `push_data`/`pull_data` contents.
- SP arithmetic is modulo 256: 8'h00−1 = 8'hFF and 8'hFF+1 = 8'h00. The page never changes.
- XFER → DONE after the N-th accepted access. DONE → IDLE, unless a new `start` is accepted in DONE.
- `sp_load` takes effect only when `busy`=0. It is ignored during XFER. If `sp_load` and an accepted `start` occur on the same edge, the load applies first and the sequence uses the loaded SP.
- `pull_data` holds its value until the next pull starts.
- `mem_wdata` = 0 whenever `mem_we`=0.

## Timing
- Reset values:
  - state IDLE
  - `sp`=`SP_RESET`
  - `pull_data`=0
  - `busy`, `done`, `mem_we`, `mem_re`, `sp_wrap` = 0
  - `mem_addr`=0, `mem_wdata`=0
- Reset asserted mid-sequence aborts immediately. Strobes drop asynchronously and no further SP change occurs.
- Strobes, address and wdata decode from registered state. They are stable for the whole access and held while `mem_ready`=0 (no timeout).
- With `mem_ready` tied high:
  - `start` is sampled at edge 0.
  - Strobes are active in cycles 1..N, one byte per cycle.
  - `done`=1 and `busy`=0 in cycle N+1.
  - Latency is N+1 cycles.
- Each low `mem_ready` cycle adds one cycle.
- `busy` = (state == XFER).
- Back-to-back operation: a `start` during the `done` cycle enters XFER on the next edge, with no idle bubble.

## Configuration
- `STACK_WRAP_FLAG_EN` defined: `sp_wrap` is set on any SP update crossing 8'h00↔8'hFF. It is cleared by `sp_load` or by reset, and set has priority over clear on the same edge.
- `STACK_WRAP_FLAG_EN` undefined: `sp_wrap` is tied to 0 and no flag register is built.

## Test plan
- Reset, then push 3 (`push_data`=24'hC0DE42), `mem_ready`=1:
  - writes C0@01FD, DE@01FC, 42@01FB
  - `sp`=8'hFA, `done` in cycle 4
- Then pull 3: reads 01FB, 01FC, 01FD → `pull_data`=24'hC0DE42, `sp`=8'hFD.
- `sp_load` 8'h00, push 1 (8'hAA):
  - write AA@0100, `sp`=8'hFF
  - `sp_wrap`=1 with `STACK_WRAP_FLAG_EN`, 0 without
- Pull 2 with `mem_ready` low 2 cycles on byte 0:
  - address and `mem_re` held
  - `done` in cycle 5
  - `sp` advances only on ready edges
- `start` while busy, `start` with `count`=0, and `sp_load` during XFER are all ignored; `sp` and the bus are unchanged.
- `rst_n` low in cycle 2 of a push 3:
  - strobes drop immediately
  - `sp`=8'hFD, state IDLE, no `done`
